// File: rtl/smiley_collision_detector.sv
// Purpose: turn smiley/object pixel overlaps into one-cycle collision pulses, one per type per frame, with frame holdoff.
// Latency: a pulse appears one clk after the overlap pixel; frameSummary updates on the startOfFrame edge.
// Backpressure: none; pause freezes detection and all frame state, and a pulse already registered still completes.
module smiley_collision_detector #(
  parameter int HOLDOFF_FRAMES = 2,
  parameter int NUM_TYPES      = 5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 pause,
  input  logic                 draw_smiley,
  input  logic                 draw_border_top,
  input  logic                 draw_border_left,
  input  logic                 draw_border_right,
  input  logic                 draw_flipper,
  input  logic                 draw_obstacle,
  output logic                 collisionSmileyBorderTop,
  output logic                 collisionSmileyBorderLeft,
  output logic                 collisionSmileyBorderRight,
  output logic                 collisionSmileyFlipper,
  output logic                 collisionSmileyObstacle,
  output logic [NUM_TYPES-1:0] frameSummary
);

  // Holdoff counter is at least one bit wide so HOLDOFF_FRAMES=0 still has a legal counter.
  localparam int              HW        = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLDOFF_FRAMES);

  logic [NUM_TYPES-1:0] overlap;
  logic [NUM_TYPES-1:0] fire;
  logic [NUM_TYPES-1:0] pulse_q;
  logic [NUM_TYPES-1:0] reported;
  logic [NUM_TYPES-1:0] accum;
  logic [HW-1:0]        holdoff [NUM_TYPES];

  // Type order: 0 top, 1 left, 2 right, 3 flipper, 4 obstacle.
  assign overlap = {draw_obstacle, draw_flipper, draw_border_right,
                    draw_border_left, draw_border_top} & {NUM_TYPES{draw_smiley}};

  // A type fires on its first unblocked overlap pixel; pre-edge reported/holdoff are used,
  // so an overlap on the startOfFrame cycle is judged against the previous frame's state.
  always_comb begin
    fire = '0;
    for (int k = 0; k < NUM_TYPES; k++) begin
      fire[k] = overlap[k] & ~reported[k] & (holdoff[k] == '0) & ~pause;
    end
  end

  // Pulse register plus per-frame bookkeeping; a fire takes priority over the frame clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pulse_q      <= '0;
      reported     <= '0;
      accum        <= '0;
      frameSummary <= '0;
      for (int k = 0; k < NUM_TYPES; k++) begin
        holdoff[k] <= '0;
      end
    end else begin
      pulse_q <= fire;
      if (!pause) begin
        if (startOfFrame) begin
          frameSummary <= accum;
          accum        <= overlap;
        end else begin
          accum <= accum | overlap;
        end
        for (int k = 0; k < NUM_TYPES; k++) begin
          if (fire[k]) begin
            reported[k] <= 1'b1;
            holdoff[k]  <= HOLD_INIT;
          end else if (startOfFrame) begin
            reported[k] <= 1'b0;
            if (holdoff[k] != '0) begin
              holdoff[k] <= holdoff[k] - HW'(1);
            end
          end
        end
      end
    end
  end

  assign collisionSmileyBorderTop   = pulse_q[0];
  assign collisionSmileyBorderLeft  = pulse_q[1];
  assign collisionSmileyBorderRight = pulse_q[2];
  assign collisionSmileyFlipper     = pulse_q[3];
  assign collisionSmileyObstacle    = pulse_q[4];

endmodule
